// File: rtl/chronospatial_pkg.sv
// Shared encodings for the run controller: host commands, FSM states, program word width.
package chronospatial_pkg;

  localparam int WORD_W = 3;

  typedef enum logic [1:0] {
    CMD_LOAD_PROG = 2'd0,
    CMD_LOAD_A    = 2'd1,
    CMD_START     = 2'd2,
    CMD_ABORT     = 2'd3
  } host_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } run_state_e;

endpackage

// File: rtl/chronospatial_out_fifo.sv
// Synchronous output FIFO with flush; head visible combinationally, push-to-head 1 cycle.
// Push and pop together while full is accepted; flush empties it on the next edge.
module chronospatial_out_fifo
  import chronospatial_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DW         = WORD_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_head_dat,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == DEPTH_C);
  assign w_pop      = i_pop & ~o_empty;
  assign w_push     = i_push & (~o_full | w_pop);
  assign o_head_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push && rstn && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/chronospatial_run_ctrl.sv
// Host-side run controller: loads program/register A, runs the core, buffers its output.
// Core output reaches out_valid 1 cycle after capture; host is stalled only while draining.
module chronospatial_run_ctrl
  import chronospatial_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int REG_A_W    = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int CYC_MAX    = 65535
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           host_valid,
  input  logic [1:0]                     host_cmd,
  input  logic [7:0]                     host_data,
  output logic                           host_ready,
  output logic                           core_rstn,
  output logic [WORD_W*PROG_DEPTH-1:0]   prog_flat,
  output logic [$clog2(PROG_DEPTH):0]    prog_len,
  output logic [REG_A_W-1:0]             reg_a_init,
  input  logic                           core_halt,
  input  logic [WORD_W-1:0]              core_out,
  input  logic                           core_out_valid,
  output logic                           out_valid,
  output logic [WORD_W-1:0]              out_data,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic                           timeout,
  output logic                           aborted,
  output logic                           start_err
);
  localparam int PW = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int LW = $clog2(PROG_DEPTH) + 1;
  localparam int CW = $clog2(CYC_MAX + 1);
  localparam int PTR_LAST_I = PROG_DEPTH - 1;
  localparam logic [PW-1:0] PTR_LAST = PTR_LAST_I[PW-1:0];
  localparam logic [LW-1:0] LEN_MAX  = PROG_DEPTH[LW-1:0];
  localparam logic [CW-1:0] CYC_LIM  = CYC_MAX[CW-1:0];

  run_state_e                 r_state;
  run_state_e                 w_state_nxt;
  logic [WORD_W*PROG_DEPTH-1:0] r_prog;
  logic [PW-1:0]              r_wr_ptr;
  logic [LW-1:0]              r_prog_len;
  logic [REG_A_W-1:0]         r_reg_a;
  logic [CW-1:0]              r_cyc;
  logic [CW-1:0]              w_cyc_nxt;
  logic r_done, r_overflow, r_timeout, r_aborted, r_start_err;
  logic w_acc, w_go, w_start_err, w_tmo, w_flush, w_finish;
  logic w_push, w_pop, w_ovf, w_fifo_full, w_fifo_empty;

  assign w_acc     = host_valid & host_ready;
  assign w_cyc_nxt = r_cyc + CW'(1);

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ABORT outranks halt and watchdog; a push in the abort cycle is discarded by the flush.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_start_err = 1'b0;
    w_tmo       = 1'b0;
    w_flush     = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc && host_cmd == CMD_START) begin
          if (r_prog_len == '0) begin
            w_start_err = 1'b1;
          end else begin
            w_go        = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (w_acc && host_cmd == CMD_ABORT) begin
          w_flush     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmo = (w_cyc_nxt == CYC_LIM);
          if (core_halt || w_tmo) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_fifo_empty) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_push = (r_state == ST_RUN) & core_out_valid & ~w_flush;
  assign w_pop  = out_valid & out_ready;
  assign w_ovf  = w_push & w_fifo_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_prog      <= '0;
      r_wr_ptr    <= '0;
      r_prog_len  <= '0;
      r_reg_a     <= '0;
      r_cyc       <= '0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
      r_aborted   <= 1'b0;
      r_start_err <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_ovf)       r_overflow  <= 1'b1;
      if (w_tmo)       r_timeout   <= 1'b1;
      if (w_flush)     r_aborted   <= 1'b1;
      if (w_start_err) r_start_err <= 1'b1;
      if (r_state == ST_RUN) r_cyc <= w_cyc_nxt;
      if (r_state == ST_IDLE && w_acc) begin
        case (host_cmd)
          CMD_LOAD_PROG: begin
            r_prog[int'(r_wr_ptr)*WORD_W +: WORD_W] <= host_data[WORD_W-1:0];
            r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (r_prog_len != LEN_MAX) r_prog_len <= r_prog_len + 1'b1;
          end
          CMD_LOAD_A: r_reg_a <= (r_reg_a >> 8) | (REG_A_W'(host_data) << (REG_A_W - 8));
          CMD_ABORT: begin
            r_wr_ptr   <= '0;
            r_prog_len <= '0;
            r_reg_a    <= '0;
          end
          default: begin
            if (w_go) begin
              r_wr_ptr    <= '0;
              r_cyc       <= '0;
              r_overflow  <= 1'b0;
              r_timeout   <= 1'b0;
              r_aborted   <= 1'b0;
              r_start_err <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  chronospatial_out_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DW         (WORD_W)
  ) u_out_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .i_flush    (w_flush),
    .i_push     (w_push),
    .i_push_dat (core_out),
    .i_pop      (w_pop),
    .o_head_dat (out_data),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  assign host_ready = rstn & (r_state != ST_DRAIN);
  assign core_rstn  = rstn & (r_state == ST_RUN);
  assign busy       = rstn & (r_state != ST_IDLE);
  assign out_valid  = rstn & ~w_fifo_empty;
  assign prog_flat  = r_prog;
  assign prog_len   = r_prog_len;
  assign reg_a_init = r_reg_a;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign timeout    = r_timeout;
  assign aborted    = r_aborted;
  assign start_err  = r_start_err;

endmodule

// File: tb/tb_chronospatial_run_ctrl.sv
// Directed bench for chronospatial_run_ctrl: reset, load, run, overflow, abort, watchdog.
module tb_chronospatial_run_ctrl;
  localparam logic [1:0] C_LOAD_PROG = 2'd0;
  localparam logic [1:0] C_LOAD_A    = 2'd1;
  localparam logic [1:0] C_START     = 2'd2;
  localparam logic [1:0] C_ABORT     = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        host_valid;
  logic [1:0]  host_cmd;
  logic [7:0]  host_data;
  logic        host_ready;
  logic        core_rstn;
  logic [47:0] prog_flat;
  logic [4:0]  prog_len;
  logic [23:0] reg_a_init;
  logic        core_halt;
  logic [2:0]  core_out;
  logic        core_out_valid;
  logic        out_valid;
  logic [2:0]  out_data;
  logic        out_ready;
  logic        busy, done, overflow, timeout, aborted, start_err;

  int n_chk  = 0;
  int n_fail = 0;

  chronospatial_run_ctrl #(
    .PROG_DEPTH (16),
    .REG_A_W    (24),
    .FIFO_DEPTH (8),
    .CYC_MAX    (100)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .host_valid     (host_valid),
    .host_cmd       (host_cmd),
    .host_data      (host_data),
    .host_ready     (host_ready),
    .core_rstn      (core_rstn),
    .prog_flat      (prog_flat),
    .prog_len       (prog_len),
    .reg_a_init     (reg_a_init),
    .core_halt      (core_halt),
    .core_out       (core_out),
    .core_out_valid (core_out_valid),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .timeout        (timeout),
    .aborted        (aborted),
    .start_err      (start_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host(input logic [1:0] cmd, input logic [7:0] dat);
    host_valid = 1'b1;
    host_cmd   = cmd;
    host_data  = dat;
    step();
    host_valid = 1'b0;
    host_data  = 8'h00;
  endtask

  initial begin
    rstn = 1'b0; host_valid = 1'b0; host_cmd = 2'd0; host_data = 8'h00;
    core_halt = 1'b0; core_out = 3'd0; core_out_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_host_ready", 64'(host_ready), 64'd0);
    check("rst_core_rstn", 64'(core_rstn), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'({busy, done, overflow, timeout, aborted, start_err}), 64'd0);
    check("rst_prog", 64'({prog_flat, prog_len, reg_a_init}), 64'd0);
    rstn = 1'b1;
    #1;
    check("rel_host_ready", 64'(host_ready), 64'd1);

    host(C_START, 8'h00);
    check("start_err_set", 64'(start_err), 64'd1);
    check("start_err_idle", 64'({busy, core_rstn}), 64'd0);

    host(C_LOAD_PROG, 8'd2); host(C_LOAD_PROG, 8'd4);
    host(C_LOAD_PROG, 8'd1); host(C_LOAD_PROG, 8'd5);
    host(C_LOAD_A, 8'h2D); host(C_LOAD_A, 8'h01); host(C_LOAD_A, 8'h00);
    check("load_prog_flat", 64'(prog_flat[11:0]), 64'b101_001_100_010);
    check("load_prog_len", 64'(prog_len), 64'd4);
    check("load_reg_a", 64'(reg_a_init), 64'h00012D);

    // Normal run: 4, 6, 3 with halt on the last word
    out_ready = 1'b1;
    host(C_START, 8'h00);
    check("run_busy_core", 64'({busy, core_rstn, start_err}), 64'b110);
    core_out_valid = 1'b1; core_out = 3'd4;
    step();
    check("run_w0", 64'({out_valid, out_data}), 64'({1'b1, 3'd4}));
    core_out = 3'd6;
    step();
    check("run_w1", 64'({out_valid, out_data}), 64'({1'b1, 3'd6}));
    core_out = 3'd3; core_halt = 1'b1;
    step();
    core_out_valid = 1'b0; core_halt = 1'b0;
    check("run_w2", 64'({out_valid, out_data}), 64'({1'b1, 3'd3}));
    check("drain_state", 64'({busy, core_rstn, done}), 64'b100);
    step();
    check("drain_empty", 64'({out_valid, busy, done}), 64'b010);
    step();
    check("run_done", 64'({done, busy}), 64'b10);
    step();
    check("done_pulse", 64'(done), 64'd0);

    // Overflow: nine words into an eight-deep FIFO with the host stalled
    out_ready = 1'b0;
    host(C_START, 8'h00);
    for (int i = 0; i < 9; i++) begin
      core_out_valid = 1'b1;
      core_out = 3'((i + 1) % 8);
      core_halt = (i == 8);
      step();
    end
    core_out_valid = 1'b0; core_halt = 1'b0;
    check("ovf_flag", 64'(overflow), 64'd1);
    step(); step();
    check("ovf_hold", 64'({out_valid, out_data, busy}), 64'({1'b1, 3'd1, 1'b1}));
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf_drain%0d", k), 64'({out_valid, out_data}), 64'({1'b1, 3'((k + 1) % 8)}));
      step();
    end
    check("ovf_empty", 64'(out_valid), 64'd0);
    step();
    check("ovf_done", 64'(done), 64'd1);

    // Abort in the same cycle as halt, with a word still buffered
    out_ready = 1'b0;
    host(C_START, 8'h00);
    check("abort_start_clr", 64'({overflow, aborted}), 64'd0);
    core_out_valid = 1'b1; core_out = 3'd5;
    step();
    check("abort_buffered", 64'(out_valid), 64'd1);
    host_valid = 1'b1; host_cmd = C_ABORT; core_halt = 1'b1; core_out = 3'd2;
    step();
    host_valid = 1'b0; core_halt = 1'b0; core_out_valid = 1'b0;
    check("abort_now", 64'({core_rstn, out_valid, aborted, busy, done}), 64'b00100);
    step();
    check("abort_no_done", 64'({done, out_valid}), 64'd0);

    // Watchdog at 100 RUN cycles
    out_ready = 1'b1;
    host(C_START, 8'h00);
    for (int c = 0; c < 99; c++) step();
    check("wd_before", 64'({timeout, core_rstn, aborted}), 64'b010);
    step();
    check("wd_fire", 64'({timeout, core_rstn, busy}), 64'b101);
    step();
    check("wd_done", 64'({done, busy}), 64'b10);

    host(C_ABORT, 8'h00);
    check("idle_abort_clr", 64'({prog_len, reg_a_init}), 64'd0);
    check("idle_abort_keep", 64'({timeout, prog_flat[11:0]}), 64'({1'b1, 12'b101_001_100_010}));

    // Reset in the middle of a run
    host(C_LOAD_PROG, 8'd7);
    host(C_START, 8'h00);
    check("mid_run", 64'(core_rstn), 64'd1);
    rstn = 1'b0;
    step();
    check("mid_rst", 64'({busy, core_rstn, done, prog_len}), 64'd0);
    rstn = 1'b1;
    step();
    check("mid_rst_nodone", 64'({done, busy}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
